// File: rtl/ysyx_23060184_lsu_axi.sv
// Load/store unit: EXU request -> address decode -> AXI4-Lite single beat -> WBU result.
// Latency: 4 cycles accept-to-out_valid with immediate grant and zero-wait slave; faults
// caught at accept (misalign, decode miss) respond in 1 cycle. Backpressure: in_ready only
// in IDLE; the result is held in RESP until out_ready, and AXI valids are held until their ready.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   in_valid/in_ready + request      mem_read, mem_write, addr, wdata_in, size, load_unsigned
//   out_valid/out_ready + result     rdata_out (extended load data), fault (00 ok, 01 misaligned,
//                                    10 decode miss, 11 bus error)
//   bus_req/bus_grant                shared-bus arbiter handshake
//   ar*/r*/aw*/w*/b*                 AXI4-Lite master channels
module ysyx_23060184_lsu_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 2,
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE  = {32'hA000_0000, 32'h8000_0000},
    parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_LIMIT = {32'hA000_0FFF, 32'h87FF_FFFF}
) (
    input  logic                    clk,
    input  logic                    resetn,
    // EXU side
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic [2:0]              size,
    input  logic                    load_unsigned,
    // WBU side
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   rdata_out,
    output logic [1:0]              fault,
    // arbiter
    output logic                    bus_req,
    input  logic                    bus_grant,
    // AXI read address
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    // AXI read data
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    // AXI write address
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    // AXI write response
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(STRB_W);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_AR   = 3'd2;
    localparam logic [2:0] S_R    = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    localparam logic [1:0] F_OK    = 2'b00;
    localparam logic [1:0] F_ALIGN = 2'b01;
    localparam logic [1:0] F_MISS  = 2'b10;
    localparam logic [1:0] F_BUS   = 2'b11;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_is_load;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_fault;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata_bus;
    logic [STRB_W-1:0]     r_wstrb;

    logic                  w_misaligned;
    logic                  w_hit;
    logic [LANE_W-1:0]     w_lane;
    logic [DATA_WIDTH-1:0] w_rshift;
    logic [6:0]            w_nbits;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_load_ext;
    logic [STRB_W-1:0]     w_strb_base;
    logic [STRB_W-1:0]     w_store_strb;
    logic [DATA_WIDTH-1:0] w_store_data;

    // An access wider than the bus is treated as misaligned as well.
    assign w_misaligned = (size > 3'(LANE_W)) ||
                          (|(addr[LANE_W-1:0] & ~({LANE_W{1'b1}} << size)));

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (addr >= SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                addr <= SLV_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_hit = 1'b1;
            end
        end
    end

    assign w_lane = r_addr[LANE_W-1:0];

    // Load path: bring the addressed lane down to bit 0, keep 2^size bytes, then extend.
    // The sign bit is the top bit of the mask, found without a variable bit index.
    assign w_rshift   = rdata >> {w_lane, 3'b000};
    assign w_nbits    = 7'd8 << r_size;
    assign w_mask     = ~({DATA_WIDTH{1'b1}} << w_nbits);
    assign w_sign     = |(w_rshift & w_mask & ~(w_mask >> 1));
    assign w_load_ext = (w_rshift & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);

    // Store path: move LSB-aligned data and its byte enables up to the addressed lane.
    assign w_strb_base  = ~({STRB_W{1'b1}} << (4'd1 << r_size));
    assign w_store_strb = w_strb_base << w_lane;
    assign w_store_data = r_wdata << {w_lane, 3'b000};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_unsigned  <= 1'b0;
            r_is_load   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rdata     <= '0;
            r_fault     <= F_OK;
            r_araddr    <= '0;
            r_awaddr    <= '0;
            r_wdata_bus <= '0;
            r_wstrb     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_addr     <= addr;
                        r_wdata    <= wdata_in;
                        r_size     <= size[1:0];
                        r_unsigned <= load_unsigned;
                        r_is_load  <= mem_read;
                        r_rdata    <= '0;
                        // A request with no memory op is a pass-through and never faults.
                        if (!mem_read && !mem_write) begin
                            r_fault <= F_OK;
                            r_state <= S_RESP;
                        end else if (w_misaligned) begin
                            r_fault <= F_ALIGN;
                            r_state <= S_RESP;
                        end else if (!w_hit) begin
                            r_fault <= F_MISS;
                            r_state <= S_RESP;
                        end else begin
                            r_fault <= F_OK;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        if (r_is_load) begin
                            r_araddr <= r_addr;
                            r_state  <= S_AR;
                        end else begin
                            r_awaddr    <= r_addr;
                            r_wdata_bus <= w_store_data;
                            r_wstrb     <= w_store_strb;
                            r_aw_done   <= 1'b0;
                            r_w_done    <= 1'b0;
                            r_state     <= S_W;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        if (rresp != 2'b00) begin
                            r_fault <= F_BUS;
                            r_rdata <= '0;
                        end else begin
                            r_fault <= F_OK;
                            r_rdata <= w_load_ext;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_W: begin
                    // AW and W complete independently; leave once both have handshaken.
                    if (awready) begin
                        r_aw_done <= 1'b1;
                    end
                    if (wready) begin
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || awready) && (r_w_done || wready)) begin
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        r_fault <= (bresp != 2'b00) ? F_BUS : F_OK;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_RESP);
    assign rdata_out = r_rdata;
    assign fault     = r_fault;

    // Held from grant until the result is presented, so the arbiter keeps the bus ours.
    assign bus_req = (r_state == S_REQ) || (r_state == S_AR) || (r_state == S_R) ||
                     (r_state == S_W)   || (r_state == S_B);

    assign araddr  = r_araddr;
    assign arvalid = (r_state == S_AR);
    assign rready  = (r_state == S_R);
    assign awaddr  = r_awaddr;
    assign awvalid = (r_state == S_W) && !r_aw_done;
    assign wdata   = r_wdata_bus;
    assign wstrb   = r_wstrb;
    assign wvalid  = (r_state == S_W) && !r_w_done;
    assign bready  = (r_state == S_B);

endmodule

// File: tb/tb_ysyx_23060184_lsu_axi.sv
module tb_ysyx_23060184_lsu_axi;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic [2:0]  size;
    logic        load_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rdata_out;
    logic [1:0]  fault;
    logic        bus_req;
    logic        bus_grant;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    // slave / arbiter configuration
    int          grant_dly = 0;
    int          ar_dly = 0;
    int          aw_dly = 0;
    int          w_dly = 0;
    logic        r_hold = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0;
    logic [1:0]  cfg_bresp = '0;

    // observed bus activity
    logic        seen_ar;
    logic        seen_req;
    logic [31:0] mon_araddr;
    logic [31:0] mon_awaddr;
    logic [31:0] mon_wdata;
    logic [3:0]  mon_wstrb;

    ysyx_23060184_lsu_axi dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata_in(wdata_in), .size(size), .load_unsigned(load_unsigned),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdata_out(rdata_out), .fault(fault),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arbiter and AXI slave model plus bus monitor, all acting on the falling edge.
    initial begin
        int g_cnt;
        int ar_cnt;
        int aw_cnt;
        int w_cnt;
        g_cnt = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        bus_grant = 0; arready = 0; awready = 0; wready = 0;
        rvalid = 0; rdata = '0; rresp = '0; bvalid = 0; bresp = '0;
        seen_ar = 0; seen_req = 0;
        mon_araddr = '0; mon_awaddr = '0; mon_wdata = '0; mon_wstrb = '0;
        forever begin
            @(negedge clk);
            bus_grant = bus_req && (g_cnt >= grant_dly);
            g_cnt     = bus_req ? g_cnt + 1 : 0;
            arready   = arvalid && (ar_cnt >= ar_dly);
            ar_cnt    = arvalid ? ar_cnt + 1 : 0;
            awready   = awvalid && (aw_cnt >= aw_dly);
            aw_cnt    = awvalid ? aw_cnt + 1 : 0;
            wready    = wvalid && (w_cnt >= w_dly);
            w_cnt     = wvalid ? w_cnt + 1 : 0;
            rvalid    = rready && !r_hold;
            rdata     = cfg_rdata;
            rresp     = cfg_rresp;
            bvalid    = bready;
            bresp     = cfg_bresp;
            if (bus_req) seen_req = 1'b1;
            if (arvalid) begin seen_ar = 1'b1; mon_araddr = araddr; end
            if (awvalid) mon_awaddr = awaddr;
            if (wvalid) begin mon_wdata = wdata; mon_wstrb = wstrb; end
        end
    end

    // Present one request at a falling edge; returns at the next falling edge (cycle 1).
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] sz, input logic uns);
        seen_ar = 1'b0;
        seen_req = 1'b0;
        in_valid = 1'b1; mem_read = rd; mem_write = wr;
        addr = a; wdata_in = wd; size = sz; load_unsigned = uns;
        @(negedge clk);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
        end
    endtask

    task automatic finish_out(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: in_ready=%b out_valid=%b bus_req=%b, required 1 0 0", in_ready, out_valid, bus_req);
        end
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi: ar/r/aw/w/b=%b, required 00000", {arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if (rdata_out !== 32'h0 || fault !== 2'b00) begin
            errors++;
            $display("FAIL reset_result: rdata_out=%h fault=%b, required 0 00", rdata_out, fault);
        end
    endtask

    task automatic test_load_word();
        int cyc;
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
        issue(1, 0, 32'h8000_0004, 32'h0, 3'd2, 0);
        wait_out(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL lw_latency: got %0d, required 4", cyc); end
        checks++;
        if (mon_araddr !== 32'h8000_0004) begin errors++; $display("FAIL lw_araddr: got %h, required 80000004", mon_araddr); end
        checks++;
        if (rdata_out !== 32'hDEAD_BEEF || fault !== 2'b00) begin
            errors++; $display("FAIL lw_data: got %h/%b, required deadbeef/00", rdata_out, fault);
        end
        finish_out("lw");
    endtask

    task automatic test_load_byte();
        int cyc;
        cfg_rdata = 32'h80FF_0000; cfg_rresp = 2'b00;
        issue(1, 0, 32'h8000_0003, 32'h0, 3'd0, 0);
        wait_out(cyc);
        checks++;
        if (rdata_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h, required ffffff80", rdata_out); end
        finish_out("lb");
        issue(1, 0, 32'h8000_0003, 32'h0, 3'd0, 1);
        wait_out(cyc);
        checks++;
        if (rdata_out !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h, required 00000080", rdata_out); end
        finish_out("lbu");
        cfg_rdata = 32'h8001_7F00;
        issue(1, 0, 32'h8000_0002, 32'h0, 3'd1, 0);
        wait_out(cyc);
        checks++;
        if (rdata_out !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_signed: got %h, required ffff8001", rdata_out); end
        finish_out("lh");
        issue(1, 0, 32'h8000_0001, 32'h0, 3'd0, 0);
        wait_out(cyc);
        checks++;
        if (rdata_out !== 32'h0000_007F) begin errors++; $display("FAIL lb_pos: got %h, required 0000007f", rdata_out); end
        finish_out("lb_pos");
    endtask

    task automatic test_store_half();
        int   cyc;
        logic w_first;
        logic aw_first;
        logic b_early;
        w_first = 0; aw_first = 0; b_early = 0;
        aw_dly = 3; w_dly = 0; cfg_bresp = 2'b00;
        issue(0, 1, 32'hA000_0002, 32'h0000_1234, 3'd1, 0);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 60) begin
            if (awvalid && !wvalid) w_first = 1'b1;
            if (wvalid && !awvalid) aw_first = 1'b1;
            if (bready && awvalid) b_early = 1'b1;
            @(negedge clk);
            cyc++;
        end
        aw_dly = 0;
        checks++;
        if (out_valid !== 1'b1 || cyc !== 7) begin errors++; $display("FAIL sh_latency: out_valid=%b cycle %0d, required 1 at 7", out_valid, cyc); end
        checks++;
        if (mon_wdata !== 32'h1234_0000 || mon_wstrb !== 4'b1100) begin
            errors++; $display("FAIL sh_wdata: got %h/%b, required 12340000/1100", mon_wdata, mon_wstrb);
        end
        checks++;
        if (mon_awaddr !== 32'hA000_0002) begin errors++; $display("FAIL sh_awaddr: got %h, required a0000002", mon_awaddr); end
        checks++;
        if ({w_first, aw_first, b_early} !== 3'b100) begin
            errors++; $display("FAIL sh_order: w_first/aw_first/b_early=%b, required 100", {w_first, aw_first, b_early});
        end
        checks++;
        if (fault !== 2'b00 || rdata_out !== 32'h0) begin errors++; $display("FAIL sh_result: got %b/%h, required 00/0", fault, rdata_out); end
        finish_out("sh");
    endtask

    task automatic test_faults();
        int cyc;
        issue(1, 0, 32'h8000_0002, 32'h0, 3'd2, 0);
        wait_out(cyc);
        checks++;
        if (fault !== 2'b01 || cyc !== 1 || seen_ar !== 1'b0) begin
            errors++; $display("FAIL misalign: fault=%b cyc=%0d ar=%b, required 01 1 0", fault, cyc, seen_ar);
        end
        finish_out("misalign");
        issue(1, 0, 32'h8000_0000, 32'h0, 3'd3, 0);
        wait_out(cyc);
        checks++;
        if (fault !== 2'b01 || seen_req !== 1'b0) begin errors++; $display("FAIL dword_on_32: fault=%b req=%b, required 01 0", fault, seen_req); end
        finish_out("dword");
        issue(1, 0, 32'h9000_0000, 32'h0, 3'd2, 0);
        wait_out(cyc);
        checks++;
        if (fault !== 2'b10 || seen_req !== 1'b0) begin errors++; $display("FAIL decode_miss: fault=%b req=%b, required 10 0", fault, seen_req); end
        finish_out("miss");
        issue(0, 1, 32'hA000_1000, 32'h55, 3'd0, 0);
        wait_out(cyc);
        checks++;
        if (fault !== 2'b10) begin errors++; $display("FAIL miss_above_limit: fault=%b, required 10", fault); end
        finish_out("miss_hi");
        cfg_rdata = 32'h0BAD_F00D; cfg_rresp = 2'b00;
        issue(1, 0, 32'h87FF_FFFC, 32'h0, 3'd2, 0);
        wait_out(cyc);
        checks++;
        if (fault !== 2'b00 || rdata_out !== 32'h0BAD_F00D || mon_araddr !== 32'h87FF_FFFC) begin
            errors++; $display("FAIL limit_hit: fault=%b data=%h ar=%h, required 00 0badf00d 87fffffc", fault, rdata_out, mon_araddr);
        end
        finish_out("limit");
        issue(0, 0, 32'h1234_5677, 32'h0, 3'd2, 0);
        wait_out(cyc);
        checks++;
        if (fault !== 2'b00 || rdata_out !== 32'h0 || cyc !== 1 || seen_req !== 1'b0) begin
            errors++; $display("FAIL no_op: fault=%b data=%h cyc=%0d req=%b, required 00 0 1 0", fault, rdata_out, cyc, seen_req);
        end
        finish_out("noop");
    endtask

    task automatic test_bus_error();
        int cyc;
        cfg_bresp = 2'b10;
        issue(0, 1, 32'h8000_0010, 32'hCAFE_F00D, 3'd2, 0);
        wait_out(cyc);
        cfg_bresp = 2'b00;
        checks++;
        if (fault !== 2'b11 || cyc !== 4) begin errors++; $display("FAIL store_berr: fault=%b cyc=%0d, required 11 4", fault, cyc); end
        checks++;
        if (mon_wdata !== 32'hCAFE_F00D || mon_wstrb !== 4'b1111) begin
            errors++; $display("FAIL sw_bus: got %h/%b, required cafef00d/1111", mon_wdata, mon_wstrb);
        end
        finish_out("berr");
        cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b11;
        issue(1, 0, 32'h8000_0008, 32'h0, 3'd2, 0);
        wait_out(cyc);
        cfg_rresp = 2'b00;
        checks++;
        if (fault !== 2'b11 || rdata_out !== 32'h0) begin errors++; $display("FAIL load_rerr: fault=%b data=%h, required 11 0", fault, rdata_out); end
        finish_out("rerr");
    endtask

    task automatic test_stall();
        int   cyc;
        int   first_ar;
        logic ready_seen;
        first_ar = 0; ready_seen = 0;
        grant_dly = 5;
        cfg_rdata = 32'h1357_9BDF;
        issue(1, 0, 32'h8000_0000, 32'h0, 3'd2, 0);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 60) begin
            if (arvalid && first_ar == 0) first_ar = cyc;
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        grant_dly = 0;
        checks++;
        if (first_ar !== 7 || cyc !== 9) begin errors++; $display("FAIL grant_wait: first arvalid %0d out %0d, required 7 9", first_ar, cyc); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (in_ready) ready_seen = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || rdata_out !== 32'h1357_9BDF || fault !== 2'b00) begin
                errors++; $display("FAIL out_hold: cycle %0d valid=%b data=%h, required 1 13579bdf", k, out_valid, rdata_out);
            end
        end
        checks++;
        if (ready_seen !== 1'b0) begin errors++; $display("FAIL in_ready_busy: got %b, required 0", ready_seen); end
        finish_out("stall");
    endtask

    task automatic test_reset_mid();
        int cyc;
        r_hold = 1'b1;
        issue(1, 0, 32'h8000_0020, 32'h0, 3'd2, 0);
        cyc = 1;
        while (rready !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL mid_reach_r: rready=%b, required 1", rready); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, out_valid, bus_req} !== 7'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: valids=%b in_ready=%b, required 0000000 1",
                {arvalid, rready, awvalid, wvalid, bready, out_valid, bus_req}, in_ready);
        end
        @(negedge clk);
        r_hold = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        cfg_rdata = 32'h0000_A5A5;
        issue(1, 0, 32'h8000_0024, 32'h0, 3'd2, 1);
        wait_out(cyc);
        checks++;
        if (rdata_out !== 32'h0000_A5A5 || fault !== 2'b00 || cyc !== 4) begin
            errors++; $display("FAIL after_reset: data=%h fault=%b cyc=%0d, required 0000a5a5 00 4", rdata_out, fault, cyc);
        end
        finish_out("post");
    endtask

    initial begin
        resetn = 1'b0;
        in_valid = 0; mem_read = 0; mem_write = 0; addr = '0; wdata_in = '0;
        size = '0; load_unsigned = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_faults();
        test_bus_error();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
